// File: rtl/bus_cmp_pkg.sv
// bus_cmp_pkg: shared state encoding, modStatus bit layout and verdict helper
package bus_cmp_pkg;
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT1   = 3'd1,
    WAIT2   = 3'd2,
    COMPARE = 3'd3,
    REPORT  = 3'd4
  } state_t;
  localparam int ST_MATCH    = 0;
  localparam int ST_TIMEOUT  = 1;
  localparam int ST_ERR      = 2;
  localparam int ST_CH1_MISS = 3;
  localparam int ST_CH2_MISS = 4;
  localparam int ST_CNT_LSB  = 5;
  // Anything that is not a clean match counts as an error.
  function automatic logic [ST_CNT_LSB-1:0] verdict_flags(input logic match, input logic timeout,
                                                          input logic ch1_miss, input logic ch2_miss);
    logic [ST_CNT_LSB-1:0] f;
    f = '0;
    f[ST_MATCH]    = match;
    f[ST_TIMEOUT]  = timeout;
    f[ST_ERR]      = !match;
    f[ST_CH1_MISS] = ch1_miss;
    f[ST_CH2_MISS] = ch2_miss;
    return f;
  endfunction
endpackage

// File: rtl/bus_compare_judge_skew_timer.sv
// skew_timer: counts wait cycles and flags the last cycle of the skew window
module skew_timer #(
  parameter int SKEW_MAX = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic term
);
  localparam int TW = $clog2(SKEW_MAX + 1);
  logic [TW-1:0] count;
  // Cleared on reset or on request, otherwise advances while waiting.
  always_ff @(posedge clk)
    if (!rst || clr) count <= '0;
    else if (inc) count <= count + 1'b1;
  assign term = count == TW'(SKEW_MAX - 1);
endmodule

// File: rtl/bus_compare_judge.sv
// bus_compare_judge: aligns two redundant bus words within a skew window and publishes a verdict byte
module bus_compare_judge
  import bus_cmp_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int SKEW_MAX   = 8
) (
  input  logic                  clk1,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] data1,
  input  logic                  valid1,
  input  logic [DATA_WIDTH-1:0] data2,
  input  logic                  valid2,
  output logic                  compResultEn,
  output logic                  compDone,
  output logic [7:0]            modStatus
);
  state_t state;
  logic [DATA_WIDTH-1:0] word1, word2;
  logic [ST_CNT_LSB-1:0] verdict;
  logic [7-ST_CNT_LSB:0] cnt_next;
  logic timer_done;
  skew_timer #(.SKEW_MAX(SKEW_MAX)) u_timer (
    .clk (clk1),
    .rst (rst),
    .clr (state == IDLE),
    .inc (state == WAIT1 || state == WAIT2),
    .term(timer_done)
  );
  // Error count saturates at all-ones and only reset clears it.
  always_comb
    cnt_next = (verdict[ST_ERR] && modStatus[7:ST_CNT_LSB] != '1) ?
               modStatus[7:ST_CNT_LSB] + 1'b1 : modStatus[7:ST_CNT_LSB];
  // Capture, align, compare and report; all outputs are registered.
  always_ff @(posedge clk1)
    if (!rst) begin
      state        <= IDLE;
      compResultEn <= 1'b0;
      compDone     <= 1'b0;
      modStatus    <= '0;
      word1        <= '0;
      word2        <= '0;
      verdict      <= '0;
    end else begin
      compDone <= 1'b0;
      case (state)
        IDLE:
          if (enable && valid1 && valid2) begin
            word1        <= data1;
            word2        <= data2;
            state        <= COMPARE;
            compResultEn <= 1'b1;
          end else if (enable && valid1) begin
            word1        <= data1;
            state        <= WAIT1;
            compResultEn <= 1'b1;
          end else if (enable && valid2) begin
            word2        <= data2;
            state        <= WAIT2;
            compResultEn <= 1'b1;
          end
        WAIT1:
          if (valid2) begin
            word2 <= data2;
            state <= COMPARE;
          end else if (valid1 || timer_done) begin
            verdict <= verdict_flags(1'b0, !valid1, 1'b0, 1'b1);
            state   <= REPORT;
          end
        WAIT2:
          if (valid1) begin
            word1 <= data1;
            state <= COMPARE;
          end else if (valid2 || timer_done) begin
            verdict <= verdict_flags(1'b0, !valid2, 1'b1, 1'b0);
            state   <= REPORT;
          end
        COMPARE: begin
          verdict <= verdict_flags(word1 == word2, 1'b0, 1'b0, 1'b0);
          state   <= REPORT;
        end
        REPORT: begin
          modStatus    <= {cnt_next, verdict};
          compDone     <= 1'b1;
          compResultEn <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_bus_compare_judge.sv
// tb_bus_compare_judge: randomized scoreboard bench with a transaction-level reference model
module tb_bus_compare_judge;
  localparam int DW = 16;
  localparam int SKEW = 8;
  typedef struct {
    logic [7:0] st;
    int         cyc;
    int         busy;
  } exp_t;
  logic clk1 = 1'b0;
  logic rst = 1'b0;
  logic enable = 1'b1;
  logic [DW-1:0] data1 = '0, data2 = '0;
  logic valid1 = 1'b0, valid2 = 1'b0;
  logic compResultEn, compDone;
  logic [7:0] modStatus;
  int cyc = 0;
  int total = 0;
  int bad = 0;
  int busy_cnt = 0;
  int model_cnt = 0;
  exp_t q[$];

  bus_compare_judge #(.DATA_WIDTH(DW), .SKEW_MAX(SKEW)) dut (
    .clk1(clk1), .rst(rst), .enable(enable),
    .data1(data1), .valid1(valid1), .data2(data2), .valid2(valid2),
    .compResultEn(compResultEn), .compDone(compDone), .modStatus(modStatus)
  );

  always #5 clk1 = ~clk1;
  always @(posedge clk1) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected verdict byte from the reporting rules: error unless a match, saturating count of 7.
  function automatic logic [7:0] expect_status(input bit match, input bit tmo, input bit c1m, input bit c2m);
    bit err;
    err = !match;
    if (err && model_cnt < 7) model_cnt++;
    return 8'(model_cnt * 32 + c2m * 16 + c1m * 8 + err * 4 + tmo * 2 + match);
  endfunction

  task automatic push(input logic [7:0] st, input int done_edge, input int first_edge);
    exp_t e;
    e.st = st;
    e.cyc = done_edge;
    e.busy = done_edge - first_edge;
    q.push_back(e);
  endtask

  task automatic strobe(input bit v1, input bit v2);
    valid1 = v1;
    valid2 = v2;
    @(negedge clk1);
    valid1 = 1'b0;
    valid2 = 1'b0;
  endtask

  // kinds: 0 simultaneous, 1 ch1 then ch2, 2 ch2 then ch1, 3 ch1 timeout, 4 ch2 timeout,
  // 5 ch1 twice, 6 ch2 twice; d is the spacing in cycles to the second strobe.
  task automatic episode(input int kind, input int d, input logic [DW-1:0] a, input logic [DW-1:0] b, input bit extra);
    int first, second;
    @(negedge clk1);
    data1 = a;
    data2 = b;
    first = cyc + 1;
    if (kind == 0) begin
      push(expect_status(a == b, 0, 0, 0), first + 2, first);
      strobe(1, 1);
      return;
    end
    strobe(kind == 1 || kind == 3 || kind == 5, kind == 2 || kind == 4 || kind == 6);
    if (kind == 3 || kind == 4) begin
      push(expect_status(0, 1, kind == 4, kind == 3), first + SKEW + 1, first);
      return;
    end
    repeat (d - 1) @(negedge clk1);
    second = cyc + 1;
    case (kind)
      1: begin push(expect_status(a == b, 0, 0, 0), second + 2, first); strobe(extra, 1); end
      2: begin push(expect_status(a == b, 0, 0, 0), second + 2, first); strobe(1, extra); end
      5: begin push(expect_status(0, 0, 0, 1), second + 1, first); strobe(1, 0); end
      default: begin push(expect_status(0, 0, 1, 0), second + 1, first); strobe(0, 1); end
    endcase
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk1);
    if (q.size() != 0) begin
      chk("drain_timeout", q.size(), 0);
      q.delete();
    end
    @(negedge clk1);
  endtask

  task automatic apply_reset(input int n);
    rst = 1'b0;
    repeat (n) @(negedge clk1);
    chk("rst_busy", compResultEn, 0);
    chk("rst_done", compDone, 0);
    chk("rst_status", modStatus, 0);
    model_cnt = 0;
    q.delete();
    rst = 1'b1;
  endtask

  // Monitor: every compDone must match the oldest expected report in value, time and busy span.
  always @(negedge clk1)
    if (!rst) busy_cnt = 0;
    else begin
      busy_cnt += int'(compResultEn);
      if (compDone) begin
        if (q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("status", modStatus, e.st);
          chk("done_cycle", cyc, e.cyc);
          chk("busy_cycles", busy_cnt, e.busy);
        end
        busy_cnt = 0;
      end
    end

  initial begin
    @(negedge clk1);
    apply_reset(2);
    episode(0, 1, 16'hA5A5, 16'hA5A5, 0);
    drain();
    episode(0, 1, 16'h1234, 16'h1236, 0);
    drain();
    for (int i = 0; i < 8; i++) begin
      episode(0, 1, 16'h1234, 16'h1236, 0);
      drain();
    end
    chk("saturated", modStatus, 8'hE4);
    episode(1, 3, 16'h00FF, 16'h00FF, 0);
    drain();
    episode(4, 1, 16'h0, 16'h0, 0);
    drain();
    episode(5, 2, 16'h0, 16'h0, 0);
    drain();
    episode(1, SKEW, 16'h0F0F, 16'h0F0F, 1);
    drain();
    episode(5, SKEW, 16'h0, 16'h0, 0);
    drain();
    // Reset during WAIT1 discards the pending comparison.
    @(negedge clk1);
    strobe(1, 0);
    @(negedge clk1);
    chk("wait_busy", compResultEn, 1);
    apply_reset(1);
    repeat (SKEW + 6) @(negedge clk1);
    chk("post_rst_status", modStatus, 0);
    // With enable low, strobes produce no activity.
    enable = 1'b0;
    strobe(1, 1);
    chk("disabled_busy", compResultEn, 0);
    strobe(0, 1);
    strobe(1, 0);
    repeat (SKEW + 6) @(negedge clk1);
    chk("disabled_idle", compResultEn, 0);
    enable = 1'b1;
    for (int i = 0; i < 60; i++) begin
      logic [DW-1:0] a, b;
      a = DW'($urandom);
      b = $urandom_range(0, 1) ? a : a ^ DW'(1 << $urandom_range(0, DW - 1));
      episode($urandom_range(0, 6), $urandom_range(1, SKEW), a, b, 1'($urandom_range(0, 1)));
      drain();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
